// File: rtl/dcache_port_merge_pkg.sv
// Shared types and helpers for the LSU-to-dcache port merger.
// Holds the response FIFO entry layout and the port-count ceiling.
package dcache_port_merge_pkg;

  localparam int NPORT_MAX = 4;
  localparam int LEADER_W  = $clog2(NPORT_MAX);
  localparam int GSIZE_W   = $clog2(NPORT_MAX) + 1;

  typedef struct packed {
    logic [LEADER_W-1:0] leader;
    logic [GSIZE_W-1:0]  size;
  } resp_entry_t;

  // True when port p falls inside the group that starts at leader and spans size ports.
  function automatic logic lane_hit(input int p, input int leader, input int size);
    return (p >= leader) && (p < leader + size);
  endfunction

endpackage

// File: rtl/pm_resp_fifo.sv
// In-order response FIFO: one {leader, size} entry per accepted dcache issue.
// The caller never pushes into a full FIFO without a simultaneous pop.
module pm_resp_fifo
  import dcache_port_merge_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = resp_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Pointer and occupancy update; pointers wrap modulo DEPTH by their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= push ? wr_ptr_r + PW'(1) : wr_ptr_r;
      rd_ptr_r <= pop  ? rd_ptr_r + PW'(1) : rd_ptr_r;
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/dcache_port_merge.sv
// Merges same-line requests from program-ordered LSU ports into one multi-lane
// dcache access and routes the lane responses back to the originating ports.
module dcache_port_merge
  import dcache_port_merge_pkg::*;
#(
  parameter int NPORT        = 2,
  parameter int OFFSET_WIDTH = 4,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NPORT-1:0]                   req,
  input  logic [NPORT-1:0][31:0]             pa,
  input  logic [NPORT-1:0]                   we,
  input  logic [NPORT-1:0][1:0]              size,
  input  logic [NPORT-1:0][3:0]              wstrb,
  input  logic [NPORT-1:0][31:0]             wdata,
  input  logic [NPORT-1:0]                   uncached,
  input  logic                               cancel,
  output logic [NPORT-1:0]                   addr_ok,
  output logic [NPORT-1:0]                   data_ok,
  output logic [NPORT-1:0][31:0]             rdata,
  output logic [NPORT-1:0]                   dc_valid,
  output logic                               dc_we,
  output logic [31-OFFSET_WIDTH:0]           dc_line,
  output logic [NPORT-1:0][OFFSET_WIDTH-1:0] dc_offset,
  output logic [NPORT-1:0][1:0]              dc_size,
  output logic [NPORT-1:0][3:0]              dc_wstrb,
  output logic [NPORT-1:0][31:0]             dc_wdata,
  output logic                               dc_uncached,
  input  logic                               dc_addr_ok,
  input  logic                               dc_data_ok,
  input  logic [NPORT-1:0][31:0]             dc_rdata,
  output logic                               busy,
  output logic                               resp_err
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic [NPORT-1:0] in_group_s;
  logic             have_leader_s;
  int               lead_s;
  int               gsize_s;
  logic             issue_en_s;
  logic             push_s;
  logic             pop_s;
  resp_entry_t      push_entry_s;
  resp_entry_t      head_s;
  logic [CW-1:0]    fifo_count_s;
  logic             fifo_empty_s;
  logic             resp_err_r;

  // Leader and contiguous same-line group; any non-matching port closes the run.
  always_comb begin
    logic found_v;
    logic open_v;
    int   lead_v;
    int   n_v;
    in_group_s = '0;
    found_v    = 1'b0;
    open_v     = 1'b0;
    lead_v     = 0;
    n_v        = 0;
    for (int p = 0; p < NPORT; p++) begin
      if (req[p] && !found_v) begin
        found_v       = 1'b1;
        lead_v        = p;
        n_v           = 1;
        in_group_s[p] = 1'b1;
        open_v        = !uncached[p];
      end else if (req[p] && open_v && !uncached[p] && (we[p] == we[lead_v]) &&
                   (pa[p][31:OFFSET_WIDTH] == pa[lead_v][31:OFFSET_WIDTH])) begin
        n_v           = n_v + 1;
        in_group_s[p] = 1'b1;
      end else begin
        open_v = 1'b0;
      end
    end
    have_leader_s = found_v;
    lead_s        = lead_v;
    gsize_s       = n_v;
  end

  // A pop in the same cycle frees the slot a full FIFO would otherwise block.
  assign issue_en_s = !reset && !cancel &&
                      ((fifo_count_s < CW'(RESP_DEPTH)) || dc_data_ok);
  assign push_s     = issue_en_s && have_leader_s && dc_addr_ok;
  assign pop_s      = !reset && dc_data_ok && !fifo_empty_s;
  assign addr_ok    = in_group_s & {NPORT{issue_en_s && dc_addr_ok}};

  assign push_entry_s.leader = LEADER_W'(lead_s);
  assign push_entry_s.size   = GSIZE_W'(gsize_s);

  // Lane j carries port lead+j; line, we and uncached come from the leader.
  always_comb begin
    logic sel_v;
    logic lead_v;
    dc_valid    = '0;
    dc_offset   = '0;
    dc_size     = '0;
    dc_wstrb    = '0;
    dc_wdata    = '0;
    dc_line     = '0;
    dc_we       = 1'b0;
    dc_uncached = 1'b0;
    for (int j = 0; j < NPORT; j++) begin
      dc_valid[j] = issue_en_s && (j < gsize_s);
      for (int p = 0; p < NPORT; p++) begin
        sel_v        = (p == lead_s + j) && (j < gsize_s);
        dc_offset[j] = dc_offset[j] | (sel_v ? pa[p][OFFSET_WIDTH-1:0] : '0);
        dc_size[j]   = dc_size[j]   | (sel_v ? size[p]  : 2'b00);
        dc_wstrb[j]  = dc_wstrb[j]  | (sel_v ? wstrb[p] : 4'b0000);
        dc_wdata[j]  = dc_wdata[j]  | (sel_v ? wdata[p] : 32'h0000_0000);
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      lead_v      = have_leader_s && (p == lead_s);
      dc_line     = dc_line | (lead_v ? pa[p][31:OFFSET_WIDTH] : '0);
      dc_we       = dc_we | (lead_v && we[p]);
      dc_uncached = dc_uncached | (lead_v && uncached[p]);
    end
  end

  // Response routing: port leader+j takes dcache lane j of the head entry.
  always_comb begin
    data_ok = '0;
    rdata   = '0;
    for (int p = 0; p < NPORT; p++) begin
      data_ok[p] = pop_s && lane_hit(p, int'(head_s.leader), int'(head_s.size));
      for (int j = 0; j < NPORT; j++) begin
        rdata[p] = rdata[p] |
                   ((pop_s && (j < int'(head_s.size)) && (p == int'(head_s.leader) + j)) ?
                    dc_rdata[j] : 32'h0000_0000);
      end
    end
  end

  // Sticky flag for a dcache response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err_r <= 1'b0;
    end else if (dc_data_ok && fifo_empty_s) begin
      resp_err_r <= 1'b1;
    end else begin
      resp_err_r <= resp_err_r;
    end
  end

  assign resp_err = resp_err_r;
  assign busy     = !fifo_empty_s;

  pm_resp_fifo #(
    .DEPTH   (RESP_DEPTH),
    .entry_t (resp_entry_t)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_dcache_port_merge.sv
// Scoreboard bench for dcache_port_merge: a 2-port and a 4-port instance share
// one stimulus set, with sel4 choosing which instance is exercised.
module tb_dcache_port_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, sel4, cancel, dc_addr_ok, dc_data_ok;
  logic [3:0]       req, we, unc;
  logic [3:0][31:0] pa, wdata, dc_rdata;
  logic [3:0][1:0]  sz;
  logic [3:0][3:0]  ws;

  logic [1:0]       req2, aok2, dok2, dcv2;
  logic             dok_in2, dc_we2, dc_unc2, busy2, err2;
  logic [1:0][31:0] rd2, dc_wdata2;
  logic [27:0]      dc_line2;
  logic [1:0][3:0]  dc_off2, dc_ws2;
  logic [1:0][1:0]  dc_sz2;

  logic [3:0]       req4, aok4, dok4, dcv4;
  logic             dok_in4, dc_we4, dc_unc4, busy4, err4;
  logic [3:0][31:0] rd4, dc_wdata4;
  logic [27:0]      dc_line4;
  logic [3:0][3:0]  dc_off4, dc_ws4;
  logic [3:0][1:0]  dc_sz4;

  assign req2    = sel4 ? 2'b00 : req[1:0];
  assign dok_in2 = sel4 ? 1'b0 : dc_data_ok;
  assign req4    = sel4 ? req : 4'b0000;
  assign dok_in4 = sel4 ? dc_data_ok : 1'b0;

  dcache_port_merge #(.NPORT(2), .OFFSET_WIDTH(4), .RESP_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .pa(pa[1:0]), .we(we[1:0]), .size(sz[1:0]),
    .wstrb(ws[1:0]), .wdata(wdata[1:0]), .uncached(unc[1:0]), .cancel(cancel),
    .addr_ok(aok2), .data_ok(dok2), .rdata(rd2), .dc_valid(dcv2), .dc_we(dc_we2),
    .dc_line(dc_line2), .dc_offset(dc_off2), .dc_size(dc_sz2), .dc_wstrb(dc_ws2),
    .dc_wdata(dc_wdata2), .dc_uncached(dc_unc2), .dc_addr_ok(dc_addr_ok),
    .dc_data_ok(dok_in2), .dc_rdata(dc_rdata[1:0]), .busy(busy2), .resp_err(err2)
  );

  dcache_port_merge #(.NPORT(4), .OFFSET_WIDTH(4), .RESP_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .pa(pa), .we(we), .size(sz),
    .wstrb(ws), .wdata(wdata), .uncached(unc), .cancel(cancel),
    .addr_ok(aok4), .data_ok(dok4), .rdata(rd4), .dc_valid(dcv4), .dc_we(dc_we4),
    .dc_line(dc_line4), .dc_offset(dc_off4), .dc_size(dc_sz4), .dc_wstrb(dc_ws4),
    .dc_wdata(dc_wdata4), .dc_uncached(dc_unc4), .dc_addr_ok(dc_addr_ok),
    .dc_data_ok(dok_in4), .dc_rdata(dc_rdata), .busy(busy4), .resp_err(err4)
  );

  logic [3:0]       o_valid, o_aok, o_dok, o_off0;
  logic [3:0][31:0] o_rd;
  logic [27:0]      o_line;
  logic             o_unc, o_busy, o_err;

  always_comb begin
    if (sel4) begin
      o_valid = dcv4;  o_aok = aok4;  o_dok = dok4;  o_rd = rd4;
      o_off0 = dc_off4[0];  o_line = dc_line4;  o_unc = dc_unc4;
      o_busy = busy4;  o_err = err4;
    end else begin
      o_valid = {2'b00, dcv2};  o_aok = {2'b00, aok2};  o_dok = {2'b00, dok2};
      o_rd = {64'h0, rd2};  o_off0 = dc_off2[0];  o_line = dc_line2;
      o_unc = dc_unc2;  o_busy = busy2;  o_err = err2;
    end
  end

  typedef struct {
    int lead;
    int n;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs already set at the negedge; checks land 1ns later.
  task automatic cyc(input string tag, input logic [3:0] e_aok, input logic [3:0] e_valid);
    exp_t       e;
    logic [3:0] e_dok;
    int         lead;
    for (int l = 0; l < 4; l++) dc_rdata[l] = $urandom();
    #1;
    chk({tag, " valid"}, 32'(o_valid), 32'(e_valid));
    chk({tag, " addr_ok"}, 32'(o_aok), 32'(e_aok));
    e_dok = 4'b0000;
    lead  = 0;
    if (dc_data_ok && !reset && sb.size() > 0) begin
      e    = sb.pop_front();
      lead = e.lead;
      for (int p = 0; p < 4; p++) e_dok[p] = (p >= e.lead) && (p < e.lead + e.n);
    end
    chk({tag, " data_ok"}, 32'(o_dok), 32'(e_dok));
    for (int p = 0; p < 4; p++)
      if (e_dok[p]) chk({tag, " rdata"}, o_rd[p], dc_rdata[p - lead]);
    if (e_aok != 4'b0000) begin
      e.lead = 0;
      while (!e_aok[e.lead]) e.lead++;
      e.n = $countones(e_aok);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;  sel4 = 1'b0;  cancel = 1'b0;  dc_addr_ok = 1'b1;  dc_data_ok = 1'b0;
    req = 4'b0000;  we = 4'b0000;  unc = 4'b0000;  pa = '0;  wdata = '0;
    dc_rdata = '0;  sz = {4{2'b10}};  ws = {4{4'hf}};
    @(negedge clk);

    // live request during reset must not be accepted
    req = 4'b0011;  pa[0] = 32'h1000;  pa[1] = 32'h1008;
    cyc("rst_req", 4'b0000, 4'b0000);
    reset = 1'b0;  req = 4'b0000;
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst err", 32'(o_err), 32'd0);

    // same-line merge
    req = 4'b0011;
    #1 chk("merge line", 32'(o_line), 32'h100);
    cyc("merge", 4'b0011, 4'b0011);
    chk("merge busy", 32'(o_busy), 32'd1);
    req = 4'b0000;  dc_data_ok = 1'b1;
    cyc("merge resp", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;
    chk("merge idle", 32'(o_busy), 32'd0);

    // line conflict: port1 follows next cycle on lane 0
    req = 4'b0011;  pa[1] = 32'h1014;
    cyc("conflict", 4'b0001, 4'b0001);
    req = 4'b0010;
    #1 chk("conflict off", 32'(o_off0), 32'd4);
    cyc("conflict p1", 4'b0010, 4'b0001);
    req = 4'b0000;  dc_data_ok = 1'b1;
    cyc("conflict r0", 4'b0000, 4'b0000);
    cyc("conflict r1", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;

    // port1 alone, then its response overlapping a new port0 issue
    req = 4'b0010;  pa[1] = 32'h2004;
    cyc("p1only", 4'b0010, 4'b0001);
    req = 4'b0001;  pa[0] = 32'h3000;  dc_data_ok = 1'b1;
    cyc("p1 resp+p0", 4'b0001, 4'b0001);
    req = 4'b0000;
    cyc("p0 resp", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;

    // uncached leader / uncached follower
    req = 4'b0011;  pa[0] = 32'h1000;  pa[1] = 32'h1008;  unc = 4'b0001;
    #1 chk("unc0 flag", 32'(o_unc), 32'd1);
    cyc("unc0", 4'b0001, 4'b0001);
    unc = 4'b0000;  req = 4'b0010;
    cyc("unc0 p1", 4'b0010, 4'b0001);
    req = 4'b0011;  unc = 4'b0010;
    cyc("unc1", 4'b0001, 4'b0001);
    req = 4'b0010;
    #1 chk("unc1 flag", 32'(o_unc), 32'd1);
    cyc("unc1 single", 4'b0010, 4'b0001);
    req = 4'b0000;  unc = 4'b0000;  dc_data_ok = 1'b1;
    repeat (4) cyc("unc drain", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;

    // store/load mix, cancel, response under cancel, dcache back-pressure
    req = 4'b0011;  we = 4'b0001;
    cyc("we mix", 4'b0001, 4'b0001);
    we = 4'b0000;  cancel = 1'b1;
    cyc("cancel", 4'b0000, 4'b0000);
    req = 4'b0000;  dc_data_ok = 1'b1;
    cyc("cancel resp", 4'b0000, 4'b0000);
    cancel = 1'b0;  dc_data_ok = 1'b0;  req = 4'b0011;  dc_addr_ok = 1'b0;
    cyc("no aok", 4'b0000, 4'b0011);
    dc_addr_ok = 1'b1;
    chk("no aok busy", 32'(o_busy), 32'd0);

    // full FIFO, then accept with a same-cycle pop
    req = 4'b0001;  pa[0] = 32'h4000;
    repeat (4) cyc("fill", 4'b0001, 4'b0001);
    chk("full busy", 32'(o_busy), 32'd1);
    cyc("full", 4'b0000, 4'b0000);
    dc_data_ok = 1'b1;
    cyc("full+pop", 4'b0001, 4'b0001);
    dc_data_ok = 1'b0;
    cyc("still full", 4'b0000, 4'b0000);
    req = 4'b0000;  dc_data_ok = 1'b1;
    repeat (4) cyc("full drain", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;
    chk("drained busy", 32'(o_busy), 32'd0);

    // spurious response is sticky
    dc_data_ok = 1'b1;
    cyc("spurious", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;
    chk("err set", 32'(o_err), 32'd1);
    cyc("idle", 4'b0000, 4'b0000);
    chk("err sticky", 32'(o_err), 32'd1);

    // reset with two entries outstanding discards them
    req = 4'b0001;
    cyc("pre rst a", 4'b0001, 4'b0001);
    cyc("pre rst b", 4'b0001, 4'b0001);
    req = 4'b0000;  reset = 1'b1;  sb.delete();
    cyc("mid rst", 4'b0000, 4'b0000);
    reset = 1'b0;
    chk("post rst busy", 32'(o_busy), 32'd0);
    chk("post rst err", 32'(o_err), 32'd0);
    dc_data_ok = 1'b1;
    cyc("stale", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;
    chk("stale err", 32'(o_err), 32'd1);

    // four-port instance: run of three, then port 3 alone
    sel4 = 1'b1;  reset = 1'b1;
    cyc("rst4", 4'b0000, 4'b0000);
    reset = 1'b0;
    req = 4'b1111;
    pa[0] = 32'h3000;  pa[1] = 32'h3004;  pa[2] = 32'h3008;  pa[3] = 32'h3010;
    cyc("run3", 4'b0111, 4'b0111);
    req = 4'b1000;
    cyc("run3 p3", 4'b1000, 4'b0001);
    req = 4'b0000;  dc_data_ok = 1'b1;
    repeat (2) cyc("run3 resp", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;

    // an idle port breaks the contiguous run
    req = 4'b1011;
    pa[0] = 32'h5000;  pa[1] = 32'h5004;  pa[3] = 32'h500c;
    cyc("gap", 4'b0011, 4'b0011);
    req = 4'b1000;
    cyc("gap p3", 4'b1000, 4'b0001);
    req = 4'b0000;  dc_data_ok = 1'b1;
    repeat (2) cyc("gap resp", 4'b0000, 4'b0000);
    dc_data_ok = 1'b0;
    chk("4p busy", 32'(o_busy), 32'd0);
    chk("4p err", 32'(o_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
